// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
//   uart_state_e      - transmitter FSM states
//   DEF_DATA_WIDTH    - default payload width (matches the team FIFO)
//   DEF_CLKS_PER_BIT  - default clk cycles per serial bit
//   START_BIT/STOP_BIT - serial line levels for frame delimiters
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side handshake between the 8-entry FIFO and its
// consumer.
//   fifo_read_en - one-cycle pop request (consumer -> FIFO)
//   fifo_empty   - FIFO empty flag (FIFO -> consumer)
//   fifo_data    - registered read data, valid the cycle after a pop
// Modports: master = consumer (UART transmitter), slave = FIFO.
interface fifo_uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  fifo_read_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;

    modport master (output fifo_read_en, input fifo_empty, input fifo_data);
    modport slave  (input fifo_read_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clk cycles within one serial bit period.
//   clk, reset - clock, async active-high reset
//   clear      - synchronous clear to the start of a bit period
//   enable     - count this cycle
//   bit_done   - one-cycle pulse on the last cycle of each bit period
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= bit_done ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from the FIFO and sends each as an 8N1 frame.
//   clk, reset   - clock, async active-high reset (abandons any frame)
//   tx_enable    - allows a new frame to start; only looked at in IDLE
//   fifo         - FIFO read-side handshake (master modport)
//   tx           - registered serial line, idles high
//   busy         - high whenever the FSM is not in IDLE
//   frames_sent  - completed-frame count, wraps silently
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_sent
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_e           state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_idx;
    logic                  tx_q;
    logic                  bit_done;
    logic                  pop;

    // Pop is gated by reset so the FIFO never loses a byte while the
    // transmitter is held in reset with data waiting.
    assign pop               = (state == IDLE) && tx_enable && !fifo.fifo_empty && !reset;
    assign fifo.fifo_read_en = pop;
    assign busy              = (state != IDLE);
    assign tx                = tx_q;

    // Counter restarts in FETCH so the start bit gets a full period.
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == FETCH),
        .enable   (state == START || state == DATA || state == STOP),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = FETCH;
            FETCH:   state_nxt = START;
            START:   if (bit_done) state_nxt = DATA;
            DATA:    if (bit_done && bit_idx == LAST_BIT) state_nxt = STOP;
            STOP:    if (bit_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx is loaded one bit ahead: each bit_done edge puts the next line
    // level on tx, so the line changes exactly on period boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q        <= STOP_BIT;
            shreg       <= '0;
            bit_idx     <= '0;
            frames_sent <= '0;
        end else begin
            case (state)
                FETCH: begin
                    shreg <= fifo.fifo_data;
                    tx_q  <= START_BIT;
                end
                START: if (bit_done) begin
                    tx_q    <= shreg[0];
                    bit_idx <= '0;
                end
                DATA: if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        tx_q <= STOP_BIT;
                    end else begin
                        tx_q    <= shreg[1];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: if (bit_done) frames_sent <= frames_sent + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
